uart_frame_scheduler: RTL and testbench

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

---
 rtl/uart_frame_scheduler_pkg.sv | 21 ++
 rtl/uart_frame_scheduler_rr_arbiter2.sv | 31 +++
 rtl/uart_frame_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_scheduler_pkg.sv
// rtl/uart_frame_scheduler_pkg.sv - shared FSM encoding, cfg field offsets and defaults
package uart_frame_scheduler_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_WAIT_IDLE = 3'd2;
    localparam logic [2:0] S_CONFIG    = 3'd3;
    localparam logic [2:0] S_WRITE     = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;

    localparam int unsigned GAP_CYCLES_DEFAULT = 400;

    // cfg word is {CtrlReg1, CtrlReg2, CtrlReg3}
    localparam int CFG_REG1_LO = 16;
    localparam int CFG_REG2_LO = 8;
    localparam int CFG_REG3_LO = 0;

    typedef logic [23:0] cfg_t;

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter2.sv
// rtl/uart_frame_scheduler_rr_arbiter2.sv - two-way round-robin pick, pointer moves on frame done
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic       winner
);

    logic last;

    // Pointer starts at requester 1 so requester 0 wins the first contest
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (done) begin
            last <= done_idx;
        end
    end

    always_comb begin
        winner = ~last;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - schedules two requesters' frames into a UART TX FIFO with config switching
module uart_frame_scheduler
    import uart_frame_scheduler_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  p_req_i,
    input  logic [7:0]  frame_len0_i,
    input  logic [7:0]  frame_len1_i,
    input  logic [7:0]  data0_i,
    input  logic [7:0]  data1_i,
    input  logic [23:0] cfg0_i,
    input  logic [23:0] cfg1_i,
    output logic [1:0]  p_ack_o,
    output logic [1:0]  p_done_o,
    output logic [7:0]  tx_data_o,
    output logic        n_we_o,
    input  logic        p_full_i,
    input  logic        p_tx_idle_i,
    output logic        p_We_o,
    output logic [7:0]  CtrlReg1_o,
    output logic [7:0]  CtrlReg2_o,
    output logic [7:0]  CtrlReg3_o,
    output logic        busy_o
);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        gnt;
    logic        winner;
    logic [7:0]  len_q;
    cfg_t        cfg_q;
    logic [8:0]  cnt;
    logic [31:0] gap_cnt;

    cfg_t        sel_cfg;
    logic [7:0]  sel_len;
    logic        frame_end;
    logic        gap_done;
    logic        write_now;
    logic        frame_done;

    assign sel_cfg    = gnt ? cfg1_i : cfg0_i;
    assign sel_len    = gnt ? frame_len1_i : frame_len0_i;
    assign frame_end  = (cnt == {1'b0, len_q});
    assign gap_done   = (gap_cnt + 32'd1) >= GAP_CYCLES;
    assign write_now  = (state == S_WRITE) && (next_state == S_HOLD);
    assign frame_done = (next_state == S_GAP) && (state != S_GAP);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (p_req_i),
        .done     (frame_done),
        .done_idx (gnt),
        .winner   (winner)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (|p_req_i) next_state = S_GRANT;
            S_GRANT:     next_state = (sel_cfg == {CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}) ? S_WRITE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (p_tx_idle_i) next_state = S_CONFIG;
            S_CONFIG:    next_state = S_WRITE;
            // Only a zero-length frame can already be at its end on entry to WRITE
            S_WRITE: begin
                if (frame_end) begin
                    next_state = S_GAP;
                end else if (!p_full_i) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD:      next_state = frame_end ? S_GAP : S_WRITE;
            S_GAP:       if (gap_done) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= 1'b0;
            len_q      <= 8'd0;
            cfg_q      <= '0;
            cnt        <= 9'd0;
            gap_cnt    <= 32'd0;
            p_ack_o    <= 2'b00;
            p_done_o   <= 2'b00;
            tx_data_o  <= 8'd0;
            n_we_o     <= 1'b1;
            p_We_o     <= 1'b0;
            CtrlReg1_o <= 8'd0;
            CtrlReg2_o <= 8'd0;
            CtrlReg3_o <= 8'd0;
            busy_o     <= 1'b0;
        end else begin
            state    <= next_state;
            busy_o   <= (next_state != S_IDLE);
            n_we_o   <= ~write_now;
            p_ack_o  <= write_now ? (2'b01 << gnt) : 2'b00;
            p_done_o <= frame_done ? (2'b01 << gnt) : 2'b00;
            p_We_o   <= (next_state == S_CONFIG);
            gap_cnt  <= (state == S_GAP) ? gap_cnt + 32'd1 : 32'd0;

            if (state == S_IDLE) begin
                gnt <= winner;
            end
            if (state == S_GRANT) begin
                len_q <= sel_len;
                cfg_q <= sel_cfg;
                cnt   <= 9'd0;
            end
            if (write_now) begin
                cnt       <= cnt + 9'd1;
                tx_data_o <= gnt ? data1_i : data0_i;
            end
            if (next_state == S_CONFIG) begin
                CtrlReg1_o <= cfg_q[CFG_REG1_LO +: 8];
                CtrlReg2_o <= cfg_q[CFG_REG2_LO +: 8];
                CtrlReg3_o <= cfg_q[CFG_REG3_LO +: 8];
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed and randomized checks of uart_frame_scheduler against a frame-level model
module tb_uart_frame_scheduler;

    localparam int unsigned GAP = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  p_req_i;
    logic [7:0]  frame_len0_i, frame_len1_i, data0_i, data1_i;
    logic [23:0] cfg0_i, cfg1_i;
    logic [1:0]  p_ack_o, p_done_o;
    logic [7:0]  tx_data_o;
    logic        n_we_o, p_full_i, p_tx_idle_i, p_We_o, busy_o;
    logic [7:0]  CtrlReg1_o, CtrlReg2_o, CtrlReg3_o;

    always #5 clk = ~clk;

    uart_frame_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .p_req_i(p_req_i),
        .frame_len0_i(frame_len0_i), .frame_len1_i(frame_len1_i),
        .data0_i(data0_i), .data1_i(data1_i), .cfg0_i(cfg0_i), .cfg1_i(cfg1_i),
        .p_ack_o(p_ack_o), .p_done_o(p_done_o), .tx_data_o(tx_data_o), .n_we_o(n_we_o),
        .p_full_i(p_full_i), .p_tx_idle_i(p_tx_idle_i), .p_We_o(p_We_o),
        .CtrlReg1_o(CtrlReg1_o), .CtrlReg2_o(CtrlReg2_o), .CtrlReg3_o(CtrlReg3_o),
        .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Requester side: frame contents, progress through them, and the frame-level model
    logic [7:0]  mem [2][256];
    int          idx [2];
    int          len [2];
    logic [23:0] cfg [2];
    bit          drop_early [2];
    logic [8:0]  exp_q[$], obs_q[$];
    int          exp_done[$], obs_done[$], wr_cyc_q[$], done_cyc_q[$];
    logic [23:0] m_applied;
    logic        m_last;
    int          exp_we, we_cnt, outstanding, last_wr_cyc, we_cyc, busy_rise;
    logic        busy_prev;
    bit          rand_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_data();
        data0_i = mem[0][8'(idx[0])];
        data1_i = mem[1][8'(idx[1])];
    endtask

    task automatic clear_obs();
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
        wr_cyc_q.delete(); done_cyc_q.delete();
        we_cnt = 0; exp_we = 0;
    endtask

    // Observe one cycle at the falling edge, then react as the requesters would
    task automatic step();
        logic full_s, idle_s;
        int r;
        @(negedge clk);
        full_s = p_full_i;
        idle_s = p_tx_idle_i;
        cyc++;
        check_eq("ack_vs_we", 32'(p_ack_o != 2'b00), 32'(!n_we_o));
        if (!n_we_o) begin
            check_eq("ack_onehot", $countones(p_ack_o), 1);
            check_eq("we_while_full", 32'(full_s), 0);
            check_eq("we_spacing", 32'((cyc - last_wr_cyc) >= 2), 1);
            last_wr_cyc = cyc;
            wr_cyc_q.push_back(cyc);
            obs_q.push_back({p_ack_o[1], tx_data_o});
        end
        if (p_done_o != 2'b00) begin
            check_eq("done_onehot", $countones(p_done_o), 1);
            r = p_done_o[1] ? 1 : 0;
            check_eq("done_count", idx[r], len[r]);
            obs_done.push_back(r);
            done_cyc_q.push_back(cyc);
            p_req_i[r] = 1'b0;
            outstanding--;
        end
        if (p_We_o) begin
            we_cnt++;
            we_cyc = cyc;
            check_eq("cfg_after_idle", 32'(idle_s), 1);
        end
        if (busy_o && !busy_prev) busy_rise = cyc;
        busy_prev = busy_o;
        for (int k = 0; k < 2; k++) begin
            if (p_ack_o[k]) begin
                idx[k]++;
                if (drop_early[k]) p_req_i[k] = 1'b0;
            end
        end
        drive_data();
        if (rand_mode) begin
            p_full_i    = ($urandom_range(0, 3) == 0);
            p_tx_idle_i = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic post(input int r, input int l, input logic [23:0] c);
        for (int i = 0; i < 256; i++) mem[r][i] = 8'($urandom);
        len[r] = l; cfg[r] = c; idx[r] = 0; drop_early[r] = 0;
        if (r == 0) begin
            frame_len0_i = 8'(l); cfg0_i = c;
        end else begin
            frame_len1_i = 8'(l); cfg1_i = c;
        end
        drive_data();
    endtask

    // Model: round-robin order, reconfigure only when a frame's cfg differs from the applied one
    task automatic launch(input bit a0, input bit a1);
        int order[$];
        int r;
        if (a0 && a1) begin
            order.push_back(m_last ? 0 : 1);
            order.push_back(m_last ? 1 : 0);
        end else if (a0) begin
            order.push_back(0);
        end else begin
            order.push_back(1);
        end
        foreach (order[k]) begin
            r = order[k];
            for (int i = 0; i < len[r]; i++) exp_q.push_back({r[0], mem[r][i]});
            if (cfg[r] != m_applied) begin
                exp_we++;
                m_applied = cfg[r];
            end
            exp_done.push_back(r);
            m_last = r[0];
            outstanding++;
        end
        p_req_i = {a1, a0};
    endtask

    task automatic finish_trial(input string tag);
        int n = 0;
        while ((outstanding > 0 || busy_o) && n < 20000) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n < 20000), 1);
        check_eq({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_ndone"}, obs_done.size(), exp_done.size());
        for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
            check_eq({tag, "_done_order"}, obs_done[i], exp_done[i]);
        check_eq({tag, "_cfg_writes"}, we_cnt, exp_we);
        check_eq({tag, "_ctrl"}, 32'({CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}), 32'(m_applied));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p_req_i = 2'b00;
        step();
        step();
        check_eq("rst_n_we", 32'(n_we_o), 1);
        check_eq("rst_tx_data", 32'(tx_data_o), 0);
        check_eq("rst_ack_done", 32'({p_ack_o, p_done_o}), 0);
        check_eq("rst_we_busy", 32'({p_We_o, busy_o}), 0);
        check_eq("rst_ctrl", 32'({CtrlReg1_o, CtrlReg2_o, CtrlReg3_o}), 0);
        rst = 1'b0;
        m_last = 1'b1;
        m_applied = 24'h0;
        outstanding = 0;
        clear_obs();
    endtask

    initial begin
        int n, k;
        bit a0, a1;
        logic [23:0] pool [3];
        rst = 1'b1; p_req_i = 2'b00; frame_len0_i = 8'd0; frame_len1_i = 8'd0;
        cfg0_i = 24'h0; cfg1_i = 24'h0; p_full_i = 1'b0; p_tx_idle_i = 1'b1;
        rand_mode = 0; last_wr_cyc = -10; busy_prev = 1'b0; we_cyc = 0; busy_rise = 0;
        idx[0] = 0; idx[1] = 0; len[0] = 0; len[1] = 0;
        drop_early[0] = 0; drop_early[1] = 0;
        for (int i = 0; i < 256; i++) begin
            mem[0][i] = 8'h0;
            mem[1][i] = 8'h0;
        end
        drive_data();
        do_reset();

        // Single frame with a config change
        post(0, 3, 24'h600011);
        mem[0][0] = 8'hA1; mem[0][1] = 8'hA2; mem[0][2] = 8'hA3;
        drive_data();
        launch(1, 0);
        finish_trial("basic");
        check_eq("basic_reg1", 32'(CtrlReg1_o), 32'h60);
        check_eq("basic_reg2", 32'(CtrlReg2_o), 32'h00);
        check_eq("basic_reg3", 32'(CtrlReg3_o), 32'h11);
        if (wr_cyc_q.size() == 3) begin
            check_eq("basic_spacing_a", wr_cyc_q[1] - wr_cyc_q[0], 2);
            check_eq("basic_spacing_b", wr_cyc_q[2] - wr_cyc_q[1], 2);
        end
        clear_obs();

        // Simultaneous requests after reset, same cfg
        do_reset();
        post(0, 2, 24'h600011);
        post(1, 2, 24'h600011);
        launch(1, 1);
        finish_trial("both");
        if (wr_cyc_q.size() == 4 && done_cyc_q.size() == 2)
            check_eq("both_gap", 32'((wr_cyc_q[2] - done_cyc_q[0]) > int'(GAP)), 1);
        clear_obs();

        // FIFO full during byte 2 of 4
        post(0, 4, m_applied);
        launch(1, 0);
        n = 0;
        while (idx[0] < 1 && n < 200) begin step(); n++; end
        check_eq("full_reach", 32'(idx[0]), 1);
        p_full_i = 1'b1;
        k = obs_q.size();
        repeat (10) step();
        check_eq("full_hold", obs_q.size(), k);
        p_full_i = 1'b0;
        finish_trial("full");
        clear_obs();

        // New cfg while the transmitter stays busy
        p_tx_idle_i = 1'b0;
        post(1, 3, 24'hABCDEF);
        launch(0, 1);
        repeat (50) step();
        check_eq("wait_we", we_cnt, 0);
        check_eq("wait_bytes", obs_q.size(), 0);
        check_eq("wait_busy", 32'(busy_o), 1);
        k = cyc;
        p_tx_idle_i = 1'b1;
        step();
        check_eq("wait_we_timing", we_cyc, k + 1);
        finish_trial("wait");
        clear_obs();

        // Zero-length frame
        post(0, 0, m_applied);
        launch(1, 0);
        finish_trial("zero");
        if (done_cyc_q.size() == 1)
            check_eq("zero_done_lat", done_cyc_q[0] - busy_rise, 2);
        clear_obs();

        // Longest frame
        post(1, 255, m_applied);
        launch(0, 1);
        finish_trial("len255");
        clear_obs();

        // Reset mid-frame
        post(0, 5, m_applied);
        launch(1, 0);
        n = 0;
        while (idx[0] < 1 && n < 200) begin step(); n++; end
        rst = 1'b1;
        p_req_i = 2'b00;
        step();
        check_eq("midrst_n_we", 32'(n_we_o), 1);
        check_eq("midrst_busy", 32'(busy_o), 0);
        check_eq("midrst_done", 32'(p_done_o), 0);
        check_eq("midrst_no_done_seen", obs_done.size(), 0);
        rst = 1'b0;
        m_last = 1'b1; m_applied = 24'h0; outstanding = 0;
        clear_obs();
        step();
        post(0, 2, 24'h600011);
        post(1, 2, 24'h600011);
        launch(1, 1);
        finish_trial("post_rst");
        clear_obs();

        // Randomized frames, FIFO back-pressure and transmitter idle
        rand_mode = 1;
        pool[1] = 24'h600011;
        pool[2] = 24'h123456;
        repeat (30) begin
            pool[0] = m_applied;
            a0 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            if (!a0 && !a1) a0 = 1;
            post(0, $urandom_range(0, 10), pool[$urandom_range(0, 2)]);
            post(1, $urandom_range(0, 10), pool[$urandom_range(0, 2)]);
            drop_early[0] = 1'($urandom_range(0, 1));
            drop_early[1] = 1'($urandom_range(0, 1));
            launch(a0, a1);
            finish_trial("rand");
            clear_obs();
        end
        rand_mode = 0;
        p_full_i = 1'b0;
        p_tx_idle_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
